dual_issue_scheduler: RTL and testbench

- Decoupling queue and slot scheduler between the dual-issue fetch stage and decode.
- Each cycle it accepts up to two fetched instructions with their PCs into a circular queue.
- Each cycle it presents up to two instructions to decode. The second slot is offered only when the pairing rules allow it.
- It absorbs decode stalls and is cleared on branch/jump correction flushes.

---
 rtl/dual_issue_scheduler.sv | 120 ++++++++++++
 tb/tb_dual_issue_scheduler.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dual_issue_scheduler.sv
// Decoupling queue between dual-issue fetch and decode. Accepts up to two instructions per cycle
// and offers up to two per cycle, pairing the second slot only when no hazard or rule forbids it.
module dual_issue_scheduler #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid_1,
    input  logic             in_valid_2,
    input  logic [31:0]      in_inst_1,
    input  logic [31:0]      in_inst_2,
    input  logic [9:0]       in_pc_1,
    input  logic [9:0]       in_pc_2,
    output logic             fetch_ready,
    input  logic             issue_stall,
    output logic             out_valid_1,
    output logic             out_valid_2,
    output logic [31:0]      out_inst_1,
    output logic [31:0]      out_inst_2,
    output logic [9:0]       out_pc_1,
    output logic [9:0]       out_pc_2,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] PAIR_MAX = (PTR_W + 1)'(DEPTH - 2);
    localparam logic [PTR_W:0] ONE      = (PTR_W + 1)'(1);

    logic [31:0]      inst_mem [DEPTH];
    logic [9:0]       pc_mem   [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] head_nxt, wr_nxt;
    logic [PTR_W:0]   count_q, count_d;
    logic [1:0]       push_n, pop_n;
    logic             push_en;
    logic             pair_ok;
    logic [4:0]       dest_head, dest_next;

    function automatic logic [4:0] dest_of(input logic [31:0] inst);
        logic [5:0] op;
        op = inst[31:26];
        if (op == 6'h00)                          return inst[15:11];
        else if (op == 6'h03)                     return 5'd31;
        else if (op[5:3] == 3'b001 || op == 6'h23) return inst[20:16];
        else                                      return 5'd0;
    endfunction

    function automatic logic is_ctrl(input logic [31:0] inst);
        logic [5:0] op;
        op = inst[31:26];
        return (op >= 6'h02 && op <= 6'h05) || (op == 6'h00 && inst[5:0] == 6'h08);
    endfunction

    function automatic logic is_mem(input logic [31:0] inst);
        return inst[31:26] == 6'h23 || inst[31:26] == 6'h2B;
    endfunction

    assign head_nxt    = rd_ptr_q + 1'b1;
    assign wr_nxt      = wr_ptr_q + 1'b1;
    assign count       = count_q;
    assign fetch_ready = count_q <= PAIR_MAX;
    assign out_inst_1  = inst_mem[rd_ptr_q];
    assign out_inst_2  = inst_mem[head_nxt];
    assign out_pc_1    = pc_mem[rd_ptr_q];
    assign out_pc_2    = pc_mem[head_nxt];
    assign out_valid_1 = count_q != '0;
    assign dest_head   = dest_of(out_inst_1);
    assign dest_next   = dest_of(out_inst_2);

    always_comb begin
        pair_ok = count_q > ONE;
        if (is_ctrl(out_inst_1)) pair_ok = 1'b0;
        if (is_mem(out_inst_1) && is_mem(out_inst_2)) pair_ok = 1'b0;
        if (dest_head != '0 &&
            (dest_head == out_inst_2[25:21] || dest_head == out_inst_2[20:16])) pair_ok = 1'b0;
        if (dest_head != '0 && dest_head == dest_next) pair_ok = 1'b0;
    end

    assign out_valid_2 = pair_ok;

    always_comb begin
        push_en  = fetch_ready & ~flush & in_valid_1;
        push_n   = push_en ? (in_valid_2 ? 2'd2 : 2'd1) : 2'd0;
        pop_n    = issue_stall ? 2'd0 : ({1'b0, out_valid_1} + {1'b0, out_valid_2});
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
        count_d  = count_q + (PTR_W + 1)'(push_n) - (PTR_W + 1)'(pop_n);
        // Flush drops both the same-cycle push and pop, regardless of stall.
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            inst_mem[wr_ptr_q] <= in_inst_1;
            pc_mem[wr_ptr_q]   <= in_pc_1;
            if (in_valid_2) begin
                inst_mem[wr_nxt] <= in_inst_2;
                pc_mem[wr_nxt]   <= in_pc_2;
            end
        end
    end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed table-driven bench for dual_issue_scheduler plus hand-written reset sequences.
module tb_dual_issue_scheduler;

    localparam logic [31:0] ADD1  = 32'h0043_0820; // add $1,$2,$3
    localparam logic [31:0] SUB4  = 32'h00A6_2022; // sub $4,$5,$6
    localparam logic [31:0] LW8   = 32'h8D28_0000; // lw $8,0($9)
    localparam logic [31:0] ADD10 = 32'h0101_5020; // add $10,$8,$1
    localparam logic [31:0] BEQ   = 32'h1022_0003; // beq $1,$2,3
    localparam logic [31:0] SW3   = 32'hAC83_0004; // sw $3,4($4)
    localparam logic [31:0] ADDI1 = 32'h20E1_0005; // addi $1,$7,5
    localparam logic [31:0] JR31  = 32'h03E0_0008; // jr $31

    logic        clk, rst, flush, in_valid_1, in_valid_2, issue_stall;
    logic [31:0] in_inst_1, in_inst_2, out_inst_1, out_inst_2;
    logic [9:0]  in_pc_1, in_pc_2, out_pc_1, out_pc_2;
    logic        fetch_ready, out_valid_1, out_valid_2;
    logic [2:0]  count;

    dual_issue_scheduler #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid_1(in_valid_1), .in_valid_2(in_valid_2),
        .in_inst_1(in_inst_1), .in_inst_2(in_inst_2),
        .in_pc_1(in_pc_1), .in_pc_2(in_pc_2),
        .fetch_ready(fetch_ready), .issue_stall(issue_stall),
        .out_valid_1(out_valid_1), .out_valid_2(out_valid_2),
        .out_inst_1(out_inst_1), .out_inst_2(out_inst_2),
        .out_pc_1(out_pc_1), .out_pc_2(out_pc_2), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl, v1, v2, st;
        logic [31:0] i1, i2;
        logic [9:0]  p1, p2;
        int          e_cnt;
        logic        e_rdy, e_ov1, e_ov2;
        logic [9:0]  e_pc1, e_pc2;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] inst_of_pc [1024];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic vec_t mk(logic fl, logic v1, logic v2, logic st,
                                logic [31:0] i1, logic [31:0] i2, logic [9:0] p1, logic [9:0] p2,
                                int e_cnt, logic e_rdy, logic e_ov1, logic e_ov2,
                                logic [9:0] e_pc1, logic [9:0] e_pc2);
        vec_t v;
        v.fl = fl; v.v1 = v1; v.v2 = v2; v.st = st;
        v.i1 = i1; v.i2 = i2; v.p1 = p1; v.p2 = p2;
        v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_ov1 = e_ov1; v.e_ov2 = e_ov2;
        v.e_pc1 = e_pc1; v.e_pc2 = e_pc2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic v1, input logic v2, input logic st,
                         input logic [31:0] i1, input logic [31:0] i2,
                         input logic [9:0] p1, input logic [9:0] p2);
        flush = fl; in_valid_1 = v1; in_valid_2 = v2; issue_stall = st;
        in_inst_1 = i1; in_inst_2 = i2; in_pc_1 = p1; in_pc_2 = p2;
    endtask

    task automatic check_state(input string tag, input int e_cnt, input logic e_rdy,
                               input logic e_ov1, input logic e_ov2,
                               input logic [9:0] e_pc1, input logic [9:0] e_pc2);
        check({tag, " count"}, 32'(count), 32'(e_cnt));
        check({tag, " fetch_ready"}, 32'(fetch_ready), 32'(e_rdy));
        check({tag, " out_valid_1"}, 32'(out_valid_1), 32'(e_ov1));
        check({tag, " out_valid_2"}, 32'(out_valid_2), 32'(e_ov2));
        if (e_ov1) begin
            check({tag, " out_pc_1"}, 32'(out_pc_1), 32'(e_pc1));
            check({tag, " out_inst_1"}, out_inst_1, inst_of_pc[e_pc1]);
        end
        if (e_ov2) begin
            check({tag, " out_pc_2"}, 32'(out_pc_2), 32'(e_pc2));
            check({tag, " out_inst_2"}, out_inst_2, inst_of_pc[e_pc2]);
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, '0, '0, '0, '0);
        foreach (inst_of_pc[i]) inst_of_pc[i] = '0;

        //       fl v1 v2 st  i1     i2     p1  p2   cnt rdy ov1 ov2 pc1 pc2
        vecs.push_back(mk(0, 0, 0, 0, 0,     0,     0,  0,   0, 1, 0, 0, 0,  0));  // idle
        vecs.push_back(mk(0, 1, 1, 0, ADD1,  SUB4,  4,  5,   2, 1, 1, 1, 4,  5));  // pair
        vecs.push_back(mk(0, 0, 0, 0, 0,     0,     0,  0,   0, 1, 0, 0, 0,  0));
        vecs.push_back(mk(0, 1, 1, 0, LW8,   ADD10, 8,  9,   2, 1, 1, 0, 8,  0));  // RAW
        vecs.push_back(mk(0, 0, 0, 0, 0,     0,     0,  0,   1, 1, 1, 0, 9,  0));
        vecs.push_back(mk(0, 0, 0, 0, 0,     0,     0,  0,   0, 1, 0, 0, 0,  0));
        vecs.push_back(mk(0, 1, 1, 0, BEQ,   ADD1,  16, 17,  2, 1, 1, 0, 16, 0));  // ctrl head
        vecs.push_back(mk(0, 0, 0, 0, 0,     0,     0,  0,   1, 1, 1, 0, 17, 0));
        vecs.push_back(mk(0, 1, 1, 0, LW8,   SW3,   20, 21,  2, 1, 1, 0, 20, 0));  // mem+mem
        vecs.push_back(mk(0, 0, 0, 0, 0,     0,     0,  0,   1, 1, 1, 0, 21, 0));
        vecs.push_back(mk(0, 1, 1, 0, ADDI1, ADD1,  24, 25,  2, 1, 1, 0, 24, 0));  // WAW
        vecs.push_back(mk(0, 1, 1, 0, JR31,  ADD1,  28, 29,  3, 0, 1, 1, 25, 28));
        vecs.push_back(mk(0, 0, 0, 0, 0,     0,     0,  0,   1, 1, 1, 0, 29, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,     0,     0,  0,   0, 1, 0, 0, 0,  0));
        vecs.push_back(mk(0, 1, 1, 1, ADD1,  SUB4,  32, 33,  2, 1, 1, 1, 32, 33)); // stalled fill
        vecs.push_back(mk(0, 1, 1, 1, ADD1,  SUB4,  34, 35,  4, 0, 1, 1, 32, 33));
        vecs.push_back(mk(0, 1, 1, 1, ADD1,  SUB4,  36, 37,  4, 0, 1, 1, 32, 33)); // dropped
        vecs.push_back(mk(0, 1, 1, 0, ADD1,  SUB4,  38, 39,  2, 1, 1, 1, 34, 35)); // dropped
        vecs.push_back(mk(0, 1, 1, 0, ADD1,  SUB4,  40, 41,  2, 1, 1, 1, 40, 41)); // wrap
        vecs.push_back(mk(0, 1, 1, 1, ADD1,  SUB4,  42, 43,  4, 0, 1, 1, 40, 41));
        vecs.push_back(mk(0, 0, 0, 0, 0,     0,     0,  0,   2, 1, 1, 1, 42, 43));
        vecs.push_back(mk(0, 1, 0, 1, ADD1,  0,     44, 0,   3, 0, 1, 1, 42, 43));
        vecs.push_back(mk(1, 1, 1, 0, ADD1,  SUB4,  46, 47,  0, 1, 0, 0, 0,  0));  // flush
        vecs.push_back(mk(0, 1, 1, 1, ADD1,  SUB4,  48, 49,  2, 1, 1, 1, 48, 49));
        vecs.push_back(mk(1, 0, 0, 1, 0,     0,     0,  0,   0, 1, 0, 0, 0,  0));  // flush+stall
        vecs.push_back(mk(0, 1, 1, 0, LW8,   ADD10, 50, 51,  2, 1, 1, 0, 50, 0));
        vecs.push_back(mk(0, 0, 1, 1, SUB4,  SUB4,  60, 61,  2, 1, 1, 0, 50, 0));  // v2 alone
        vecs.push_back(mk(0, 0, 0, 0, 0,     0,     0,  0,   1, 1, 1, 0, 51, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,     0,     0,  0,   0, 1, 0, 0, 0,  0));

        foreach (vecs[i]) begin
            if (vecs[i].v1) inst_of_pc[vecs[i].p1] = vecs[i].i1;
            if (vecs[i].v2) inst_of_pc[vecs[i].p2] = vecs[i].i2;
        end
        inst_of_pc[70] = ADD1;
        inst_of_pc[71] = SUB4;

        // Reset state, then release with idle inputs.
        #2;
        check_state("reset", 0, 1'b1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_state("post_reset_idle", 0, 1'b1, 1'b0, 1'b0, '0, '0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].fl, vecs[i].v1, vecs[i].v2, vecs[i].st,
                  vecs[i].i1, vecs[i].i2, vecs[i].p1, vecs[i].p2);
            @(posedge clk); #1;
            check_state($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_rdy,
                        vecs[i].e_ov1, vecs[i].e_ov2, vecs[i].e_pc1, vecs[i].e_pc2);
        end

        // Asynchronous reset mid-stream must clear outputs before any clock edge.
        @(negedge clk);
        drive(0, 1, 1, 1, ADD1, SUB4, 70, 71);
        @(posedge clk); #1;
        check_state("pre_async", 2, 1'b1, 1'b1, 1'b1, 70, 71);
        drive(0, 0, 0, 1, '0, '0, '0, '0);
        #1 rst = 1'b0;
        #1;
        check_state("async_reset", 0, 1'b1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, '0, '0, '0, '0);
        @(posedge clk); #1;
        check_state("after_async", 0, 1'b1, 1'b0, 1'b0, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
